// File: rtl/adc_sample_averager.sv
// Block averager for the ADC sample stream: sums 2^N unsigned samples, emits one
// decimated average per window over valid/ready, and tracks a hysteresis alarm.
module adc_sample_averager #(
  parameter int DATA_WIDTH   = 32,
  parameter int LOG2_AVG_MAX = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [3:0]            avg_log2,
  input  logic [DATA_WIDTH-1:0] threshold_high,
  input  logic [DATA_WIDTH-1:0] threshold_low,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  alarm,
  output logic [15:0]           windows_completed,
  output logic [1:0]            avg_state_out
);

  // state  | meaning
  // IDLE   | disabled; accumulator, counter, alarm and window count cleared
  // ACCUM  | accepting samples of the current window
  // OUTPUT | holding an average until the downstream accepts it
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCUM   = 2'b01,
    OUTPUT  = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  localparam int         ACC_W = DATA_WIDTH + LOG2_AVG_MAX;
  localparam int         CNT_W = LOG2_AVG_MAX + 1;
  localparam logic [3:0] N_MAX = 4'(LOG2_AVG_MAX);

  state_t                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            n_q, n_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  alarm_q, alarm_d;
  logic [15:0]           win_q, win_d;

  logic [3:0]            n_clamp, n_eff;
  logic [ACC_W-1:0]      sum;
  logic [DATA_WIDTH-1:0] avg;
  logic                  last_sample;
  logic                  in_ready_c;

  // The window exponent is sampled only on the first sample of a window.
  assign n_clamp     = (avg_log2 > N_MAX) ? N_MAX : avg_log2;
  assign n_eff       = (cnt_q == '0) ? n_clamp : n_q;
  assign sum         = acc_q + ACC_W'(in_data);
  assign avg         = DATA_WIDTH'(sum >> n_eff);
  assign last_sample = (cnt_q + CNT_W'(1)) == (CNT_W'(1) << n_eff);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    alarm_d     = alarm_q;
    win_d       = win_q;
    in_ready_c  = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d   = '0;
        cnt_d   = '0;
        alarm_d = 1'b0;
        win_d   = '0;
        if (enable) state_d = ACCUM;
      end
      ACCUM: begin
        in_ready_c = enable;
        if (enable && in_valid) begin
          if (cnt_q == '0) n_d = n_clamp;
          if (last_sample) begin
            out_data_d  = avg;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = OUTPUT;
            if (avg > threshold_high)     alarm_d = 1'b1;
            else if (avg < threshold_low) alarm_d = 1'b0;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (!enable) begin
          state_d = IDLE;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (win_q != 16'hFFFF) win_d = win_q + 16'd1;
          state_d = enable ? ACCUM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      n_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      alarm_q     <= 1'b0;
      win_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      alarm_q     <= alarm_d;
      win_q       <= win_d;
    end
  end

  assign in_ready          = in_ready_c;
  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign alarm             = alarm_q;
  assign windows_completed = win_q;
  assign avg_state_out     = state_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed and randomized bench for adc_sample_averager against a queue-based
// reference model of window averages, alarm hysteresis and window counting.
module tb_adc_sample_averager;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [3:0]  avg_log2;
  logic [31:0] threshold_high, threshold_low;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        alarm;
  logic [15:0] windows_completed;
  logic [1:0]  avg_state_out;

  int n_cmp = 0;
  int n_err = 0;
  bit m_alarm = 1'b0;
  int m_win = 0;

  adc_sample_averager #(.DATA_WIDTH(32), .LOG2_AVG_MAX(4)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .avg_log2(avg_log2),
    .threshold_high(threshold_high), .threshold_low(threshold_low),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .alarm(alarm), .windows_completed(windows_completed), .avg_state_out(avg_state_out)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Holds in_valid with the sample until the DUT takes it; in_valid stays high on return.
  task automatic push(input logic [31:0] d);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (in_ready) done = 1'b1;
      tick();
    end
    check("push_accepted", done, 1);
  endtask

  function automatic logic [31:0] ref_avg(input logic [31:0] s[$], input int n);
    longint unsigned total = 0;
    foreach (s[i]) total += s[i];
    return 32'(total >> n);
  endfunction

  function automatic bit next_alarm(input bit cur, input logic [31:0] a,
                                    input logic [31:0] hi, input logic [31:0] lo);
    if (a > hi) return 1'b1;
    if (a < lo) return 1'b0;
    return cur;
  endfunction

  task automatic finish_window(input logic [31:0] exp_d, input bit exp_al, input int hold);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (out_valid) seen = 1'b1;
      else tick();
    end
    check("out_valid_seen", seen, 1);
    check("out_data", out_data, exp_d);
    check("alarm", alarm, exp_al);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, exp_d);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (m_win < 65535) m_win++;
    check("windows", windows_completed, m_win);
    check("valid_drop", out_valid, 0);
  endtask

  // One window of random samples with random gaps and a mid-window avg_log2 change.
  task automatic run_window(input int nreq, input int hold);
    logic [31:0] s[$];
    logic [31:0] v;
    int n;
    n = (nreq > 4) ? 4 : nreq;
    avg_log2 = 4'(nreq);
    for (int i = 0; i < (1 << n); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      v = $urandom;
      s.push_back(v);
      push(v);
      if (i == 0) avg_log2 = 4'($urandom_range(0, 15));
    end
    in_valid = 1'b0;
    v = ref_avg(s, n);
    m_alarm = next_alarm(m_alarm, v, threshold_high, threshold_low);
    finish_window(v, m_alarm, hold);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] t4_in[5];
    bit          t4_al[5];
    logic [31:0] a;

    reset_n = 1'b1; enable = 1'b0; avg_log2 = 4'd0;
    threshold_high = 32'hFFFF_FFFF; threshold_low = 32'd0;
    in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    #1 reset_n = 1'b0;
    repeat (2) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_alarm", alarm, 0);
    check("rst_windows", windows_completed, 0);
    check("rst_state", avg_state_out, 0);
    reset_n = 1'b1;
    tick();
    check("idle_hold", avg_state_out, 0);

    // T1: back-to-back window, downstream always ready
    enable = 1'b1; avg_log2 = 4'd2; out_ready = 1'b1;
    tick();
    check("t1_accum", avg_state_out, 1);
    push(10); push(20); push(30); push(41);
    in_valid = 1'b0;
    #1;
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 25);
    check("t1_in_ready", in_ready, 0);
    check("t1_state", avg_state_out, 2);
    tick();
    m_win = 1;
    check("t1_windows", windows_completed, 1);
    check("t1_valid_drop", out_valid, 0);
    check("t1_back_accum", avg_state_out, 1);
    out_ready = 1'b0;

    // T2: backpressure for 5 cycles while upstream keeps offering
    push(10); push(20); push(30); push(41);
    finish_window(25, 1'b0, 5);
    in_valid = 1'b0;
    #1;
    check("t2_ready_after", in_ready, 1);

    // T3: full-scale samples, oversize exponent clamps to 16
    avg_log2 = 4'd9;
    for (int i = 0; i < 15; i++) push(32'hFFFF_FFFF);
    in_valid = 1'b0;
    #1;
    check("t3_no_early_out", out_valid, 0);
    push(32'hFFFF_FFFF);
    in_valid = 1'b0;
    m_alarm = next_alarm(m_alarm, 32'hFFFF_FFFF, threshold_high, threshold_low);
    finish_window(32'hFFFF_FFFF, m_alarm, 0);

    // T4: pass-through with hysteresis alarm
    threshold_high = 100; threshold_low = 50; avg_log2 = 4'd0;
    t4_in = '{120, 80, 40, 80, 101};
    t4_al = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      push(t4_in[i]);
      in_valid = 1'b0;
      m_alarm = t4_al[i];
      finish_window(t4_in[i], t4_al[i], 0);
    end

    // Randomized windows against the reference model
    for (int w = 0; w < 20; w++) begin
      threshold_high = $urandom;
      threshold_low  = $urandom;
      run_window($urandom_range(0, 6), $urandom_range(0, 3));
    end

    // T5: partial window dropped by enable low, then a fresh window
    avg_log2 = 4'd2;
    push(7); push(9);
    in_valid = 1'b0;
    enable = 1'b0;
    tick();
    check("t5_idle", avg_state_out, 0);
    tick();
    m_alarm = 1'b0; m_win = 0;
    check("t5_no_valid", out_valid, 0);
    check("t5_alarm_clr", alarm, 0);
    check("t5_windows_clr", windows_completed, 0);
    enable = 1'b1;
    tick();
    push(4);
    avg_log2 = 4'd0;
    #1;
    check("t5_no_early_out", out_valid, 0);
    push(4); push(4); push(4);
    in_valid = 1'b0;
    m_alarm = next_alarm(m_alarm, 4, threshold_high, threshold_low);
    finish_window(4, m_alarm, 0);

    // Pending result survives enable low, then the block idles
    avg_log2 = 4'd0;
    a = $urandom;
    push(a);
    in_valid = 1'b0;
    enable = 1'b0;
    m_alarm = next_alarm(m_alarm, a, threshold_high, threshold_low);
    repeat (3) tick();
    check("pend_valid", out_valid, 1);
    check("pend_data", out_data, a);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pend_windows", windows_completed, m_win + 1);
    check("pend_idle", avg_state_out, 0);
    tick();
    m_win = 0; m_alarm = 1'b0;
    check("pend_windows_clr", windows_completed, 0);

    // T6: async reset while holding a result
    enable = 1'b1; threshold_high = 0; threshold_low = 0; avg_log2 = 4'd1;
    tick();
    q = {32'd10, 32'd20};
    push(q[0]); push(q[1]);
    in_valid = 1'b0;
    finish_window(ref_avg(q, 1), 1'b1, 0);
    push(30); push(40);
    in_valid = 1'b0;
    #1;
    check("t6_pre_valid", out_valid, 1);
    check("t6_pre_alarm", alarm, 1);
    check("t6_pre_windows", windows_completed, 1);
    reset_n = 1'b0;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_alarm", alarm, 0);
    check("t6_windows", windows_completed, 0);
    check("t6_state", avg_state_out, 0);
    check("t6_data", out_data, 0);
    check("t6_in_ready", in_ready, 0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
